// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one registered 4-bit ALU between two requesters.
// Each accepted op runs IDLE -> EXEC -> WAIT -> RESP. Arbitration is round-robin
// and happens only in IDLE. Per-requester completion counters are kept.
module alu_rr_scheduler #(
  parameter int FIRST_GRANT = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req0_op,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [3:0]       req1_op,
  // shared ALU
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_s,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  // response
  output logic             resp_valid,
  output logic             resp_id,
  output logic [3:0]       resp_f,
  output logic             resp_cout,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  // last_grant starts on the requester that must lose the first tie
  localparam logic LAST_GRANT_RST = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             winner;
  logic             accept;
  logic [3:0]       a_q, b_q, op_q;
  logic             id_q;
  logic [3:0]       resp_f_q;
  logic             resp_cout_q, resp_err_q, resp_id_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             op_undef;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: the only conditional transition is the accept out of IDLE
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = WAIT;
      WAIT: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else if (req1_valid)          winner = 1'b1;
  end

  // Output logic: handshake, busy and the response strobe
  always_comb begin
    req0_ready = (state_q == IDLE) && !reset && !winner && req0_valid;
    req1_ready = (state_q == IDLE) && !reset &&  winner && req1_valid;
    accept     = req0_ready || req1_ready;
    busy       = (state_q != IDLE);
    resp_valid = (state_q == RESP);
  end

  // The four codes with S[2]=1 and Cin=0 are undefined; the ALU returns 0 for them
  assign op_undef = (op_q == 4'b1000) || (op_q == 4'b1010) ||
                    (op_q == 4'b1100) || (op_q == 4'b1110);

  // Datapath: latch the winning op, capture the ALU result, count completions
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= LAST_GRANT_RST;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      resp_f_q     <= '0;
      resp_cout_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_id_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      if (accept) begin
        a_q          <= winner ? req1_a  : req0_a;
        b_q          <= winner ? req1_b  : req0_b;
        op_q         <= winner ? req1_op : req0_op;
        id_q         <= winner;
        last_grant_q <= winner;
      end
      if (state_q == WAIT) begin
        resp_f_q    <= alu_f;
        resp_cout_q <= alu_cout;
        resp_err_q  <= op_undef;
        resp_id_q   <= id_q;
      end
      if (state_q == RESP) begin
        if (id_q) cnt1_q <= cnt1_q + 1'b1;
        else      cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  // ALU lines come straight from the op registers, so they only move after an accept
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_s     = op_q[3:1];
  assign alu_cin   = op_q[0];
  assign resp_f    = resp_f_q;
  assign resp_cout = resp_cout_q;
  assign resp_err  = resp_err_q;
  assign resp_id   = resp_id_q;
  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a small registered-ALU model.
// Expected results are hand-computed constants.
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
  logic [3:0] alu_a, alu_b, alu_f;
  logic [2:0] alu_s;
  logic       alu_cin, alu_cout;
  logic       resp_valid, resp_id, resp_cout, resp_err, busy;
  logic [3:0] resp_f;
  logic [7:0] done_cnt0, done_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.FIRST_GRANT(0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_f(resp_f),
    .resp_cout(resp_cout), .resp_err(resp_err), .busy(busy),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  // Registered ALU model covering the opcodes this bench uses
  always @(posedge clk) begin
    logic [4:0] r;
    if (reset) r = 5'd0;
    else begin
      case ({alu_s, alu_cin})
        4'b0000: r = {1'b0, alu_a};                          // pass A
        4'b0100: r = {1'b0, alu_a} + 5'd1;                   // A + 1
        4'b0101: r = {1'b0, alu_a} + {1'b0, alu_b};          // A + B
        4'b0110: r = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;  // A - B
        default: r = 5'd0;                                   // undefined codes
      endcase
    end
    alu_f    <= r[3:0];
    alu_cout <= r[4];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    #1;
  endtask

  task automatic wait_ready(input logic id);
    int n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("ready_timeout", 0, 1);
  endtask

  // Full op from request to the first IDLE cycle after the response
  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] ef, input logic ec,
                       input logic ee, input bit chk);
    drive(id, a, b, op);
    wait_ready(id);
    if (chk) check("ready_other", id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (chk) begin
      check("exec_alu_a", alu_a, a);
      check("exec_alu_sel", {alu_s, alu_cin}, op);
      check("exec_busy", busy, 1);
    end
    tick();
    tick();
    if (chk) begin
      check("resp_valid", resp_valid, 1);
      check("resp_id", resp_id, id);
      check("resp_f", resp_f, ef);
      check("resp_cout", resp_cout, ec);
      check("resp_err", resp_err, ee);
    end
    tick();
    if (chk) check("idle_after_resp", {busy, resp_valid}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0; req0_op = 4'd0;
    req1_valid = 1'b1; req1_a = 4'd0; req1_b = 4'd0; req1_op = 4'd0;
    tick();
    tick();
    // Reset state, with both valids high
    check("rst_readys", {req0_ready, req1_ready}, 0);
    check("rst_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
    check("rst_resp", {resp_valid, resp_id, resp_f, resp_cout, resp_err}, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {done_cnt0, done_cnt1}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Req0 alone: 3 + 5 = 8
    do_op(1'b0, 4'd3, 4'd5, 4'b0101, 4'd8, 1'b0, 1'b0, 1'b1);
    check("t1_cnt0", done_cnt0, 1);
    check("t1_hold_f", resp_f, 8);

    // Continuous contention after reset: ids alternate 0,1,0,1
    do_reset();
    drive(1'b0, 4'd15, 4'd0, 4'b0100);
    drive(1'b1, 4'd2, 4'd5, 4'b0110);
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = i[0];
      wait_ready(exp_id);
      check("rr_ready0", req0_ready, !exp_id);
      check("rr_ready1", req1_ready, exp_id);
      tick();
      tick();
      tick();
      check("rr_resp_valid", resp_valid, 1);
      check("rr_resp_id", resp_id, exp_id);
      check("rr_resp_f", resp_f, exp_id ? 4'd13 : 4'd0);
      check("rr_resp_cout", resp_cout, exp_id ? 1'b0 : 1'b1);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_cnts", {done_cnt0, done_cnt1}, {8'd2, 8'd2});

    // Undefined opcode from req1
    do_op(1'b1, 4'd9, 4'd6, 4'b1000, 4'd0, 1'b0, 1'b1, 1'b1);
    check("err_cnt1", done_cnt1, 3);

    // Reset during WAIT aborts the op
    drive(1'b0, 4'd1, 4'd1, 4'b0101);
    wait_ready(1'b0);
    tick();
    req0_valid = 1'b0;
    tick();
    check("abort_in_wait", busy, 1);
    reset = 1'b1;
    tick();
    check("abort_state", {busy, resp_valid, req0_ready}, 0);
    check("abort_alu", {alu_a, alu_b, alu_s, alu_cin}, 0);
    check("abort_resp", {resp_id, resp_f, resp_cout, resp_err}, 0);
    check("abort_cnts", {done_cnt0, done_cnt1}, 0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    check("abort_no_resp", seen, 0);
    do_op(1'b0, 4'd7, 4'd0, 4'b0000, 4'd7, 1'b0, 1'b0, 1'b1);

    // Operand change after accept is ignored
    drive(1'b0, 4'd4, 4'd0, 4'b0000);
    wait_ready(1'b0);
    tick();
    req0_valid = 1'b0;
    req0_a = 4'd9;
    tick();
    tick();
    check("late_change_valid", resp_valid, 1);
    check("late_change_f", resp_f, 4);
    tick();

    // 256 back-to-back req0 ops wrap the 8-bit counter
    do_reset();
    for (int i = 0; i < 255; i++) do_op(1'b0, 4'd1, 4'd0, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt0_255", done_cnt0, 255);
    do_op(1'b0, 4'd2, 4'd0, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b1);
    check("wrap_cnt0", done_cnt0, 0);
    check("wrap_cnt1", done_cnt1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares the single 4-bit registered ALU between two requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU operand/select lines, and captures the registered ALU result. It returns the result to the winning requester with a tagged one-cycle response pulse and keeps per-requester completion counters. It sits between the two datapath clients and the ALU instance; the ALU's own reset is tied to the same `reset` net.

## Interface
- `FIRST_GRANT`, default 0: requester that wins the first contested arbitration after reset (0 or 1).
- `CNT_W`, default 8: width of each completion counter.

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req0_valid` input 1: requester 0 has an op pending.
- `req0_ready` output 1: requester 0 accepted this cycle.
- `req0_a`, `req0_b` input 4 each: operands.
- `req0_op` input 4: ALU opcode {S[2:0],Cin}.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0.
- `alu_a`, `alu_b` output 4 each: ALU operands.
- `alu_s` output 3: ALU select.
- `alu_cin` output 1: ALU Cin.
- `alu_f` input 4: registered ALU result.
- `alu_cout` input 1: registered ALU carry.
- `resp_valid` output 1: one-cycle result pulse.
- `resp_id` output 1: requester that owns the response.
- `resp_f` output 4: result.
- `resp_cout` output 1: carry.
- `resp_err` output 1: opcode was one of the undefined codes.
- `busy` output 1: state is not IDLE.
- `done_cnt0`, `done_cnt1` output CNT_W each: responses delivered per requester.

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP.
  - IDLE -> EXEC on accept.
  - EXEC -> WAIT and WAIT -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Arbitration in IDLE only:
  - One requester valid: it wins.
  - Both valid: the requester not in `last_grant` wins.
  - `last_grant` resets to 1-FIRST_GRANT and updates on every accept.
- `reqN_ready` is combinational: (state==IDLE) && !reset && winner==N && reqN_valid. At most one ready is high per cycle. Accept = valid && ready.
- On accept, register a, b, op and id. `alu_a`/`alu_b`/`alu_s`/`alu_cin` are driven from these registers and held stable through EXEC and WAIT. In IDLE they hold their last values.
- In WAIT, `alu_f`/`alu_cout` are registered into `resp_f`/`resp_cout`. `resp_err` = op ∈ {1000,1010,1100,1110}; the op still runs and the ALU yields F=0, Cout=0.
- In RESP: `resp_valid`=1 and `resp_id`=latched id. The matching `done_cntN` increments by 1 at the end of RESP and wraps to 0 modulo 2^CNT_W.
- `resp_f`, `resp_cout`, `resp_err` and `resp_id` hold their values after RESP until the next WAIT.
- Requesters keep valid high until ready. Operand changes before accept are permitted; changes after accept are ignored.

## Timing
- Accept at cycle T.
  - T+1: EXEC, ALU inputs valid; the ALU registers at the end of T+1.
  - T+2: WAIT, `alu_f` valid, captured at the end of T+2.
  - T+3: RESP, `resp_valid`=1.
  - T+4: IDLE, next accept possible.
- Latency accept-to-response is 3 cycles. Throughput is 1 op per 4 cycles.
- `busy`=1 during T+1..T+3.
- A requester whose valid rises during a busy period waits. In the first IDLE cycle, round-robin applies.
- Reset values (applied at the first edge with `reset`=1):
  - state IDLE, `last_grant`=1-FIRST_GRANT;
  - `alu_a`=`alu_b`=0, `alu_s`=0, `alu_cin`=0;
  - `resp_valid`=0, `resp_id`=0, `resp_f`=0, `resp_cout`=0, `resp_err`=0;
  - `busy`=0, both counters 0;
  - both readys 0 while `reset`=1.
- Reset mid-operation (EXEC/WAIT/RESP) aborts the op. No response pulse follows, the counter does not increment, and the dropped op is not replayed.
- Simultaneous valid in IDLE with equal priority history: the FIRST_GRANT requester wins first, then the two strictly alternate while both stay valid.

## Test plan
- Req0 only, op 0101, a=3, b=5 -> `req0_ready` at T, `resp_valid` at T+3 with id=0, f=8, cout=0, err=0, `done_cnt0`=1.
- Both valid continuously, req0 op 0100 a=15, req1 op 0110 a=2 b=5 -> responses alternate id 0,1,0,1 every 4 cycles. Id 0 gives f=0, cout=1; id 1 gives f=13, cout=0.
- Req1 op 1000 a=9 b=6 -> f=0, cout=0, err=1, `done_cnt1` increments.
- Assert reset during WAIT -> no `resp_valid`, all outputs at reset values next cycle, counters 0. A subsequent req0 op 0000 a=7 completes with f=7 at T+3.
- Req0 changes a from 4 to 9 one cycle after accept, op 0000 -> f=4.
- 256 back-to-back req0 ops with CNT_W=8 -> `done_cnt0` wraps to 0 and `done_cnt1` stays 0.
